// File: rtl/des_ks_pkg.sv
// DES key-schedule constants and C/D rotation helpers, shared by des_key_schedule and des_pc2.
// Tables keep the usual DES 1-based bit numbering: bit 1 is the MSB.
package des_ks_pkg;

    typedef enum logic [0:0] {StIdle, StRun} ks_state_e;

    localparam int unsigned PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Shift table stored 0-based: S[i] is the shift for round i+1.
    localparam int unsigned S [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [1:28] rotl28(input logic [1:28] x, input int unsigned amt);
        return (amt == 2) ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input int unsigned amt);
        return (amt == 2) ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation: 56-bit C/D state to 48-bit round subkey.
module des_pc2
    import des_ks_pkg::*;
(
    input  logic [1:56] cd,
    output logic [1:48] subkey
);

    for (genvar i = 1; i <= 48; i++) begin : g_pc2
        assign subkey[i] = cd[PC2[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one key in, 16 subkeys out over valid/ready.
// Optional key parity checking is enabled with `define DES_KS_PARITY_CHECK_EN.
module des_key_schedule
    import des_ks_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:64] key,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        decrypt,
    output logic [1:48] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        last,
    output logic        key_err
);

    ks_state_e   state_q;
    logic [1:28] c_q, d_q;
    logic [3:0]  rnd_q;
    logic        dec_q;
    logic        key_ready_q, subkey_valid_q, last_q, key_err_q;

    logic [1:56] pc1_cd;
    logic [1:28] load_c, load_d, adv_c, adv_d;
    logic        parity_ok;

    for (genvar i = 1; i <= 56; i++) begin : g_pc1
        assign pc1_cd[i] = key[PC1[i]];
    end

`ifdef DES_KS_PARITY_CHECK_EN
    logic [7:0] byte_odd;
    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_odd[b] = ^key[8*b+1 : 8*b+8];
    end
    assign parity_ok = &byte_odd;
`else
    logic unused_parity;
    assign unused_parity = ^{key[8], key[16], key[24], key[32],
                             key[40], key[48], key[56], key[64]};
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        // Decrypt starts from C0/D0 since K16 = PC-2(C16, D16) and C16/D16 equal C0/D0.
        load_c = decrypt ? pc1_cd[1:28]  : rotl28(pc1_cd[1:28], S[0]);
        load_d = decrypt ? pc1_cd[29:56] : rotl28(pc1_cd[29:56], S[0]);
        if (dec_q) begin
            adv_c = rotr28(c_q, S[4'd15 - rnd_q]);
            adv_d = rotr28(d_q, S[4'd15 - rnd_q]);
        end else begin
            adv_c = rotl28(c_q, S[rnd_q + 4'd1]);
            adv_d = rotl28(d_q, S[rnd_q + 4'd1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            c_q            <= '0;
            d_q            <= '0;
            rnd_q          <= '0;
            dec_q          <= 1'b0;
            key_ready_q    <= 1'b1;
            subkey_valid_q <= 1'b0;
            last_q         <= 1'b0;
            key_err_q      <= 1'b0;
        end else begin
            key_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (key_valid) begin
                        if (parity_ok) begin
                            state_q        <= StRun;
                            c_q            <= load_c;
                            d_q            <= load_d;
                            rnd_q          <= '0;
                            dec_q          <= decrypt;
                            key_ready_q    <= 1'b0;
                            subkey_valid_q <= 1'b1;
                            last_q         <= 1'b0;
                        end else begin
                            // Bad key is consumed but produces no subkeys.
                            key_err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (subkey_ready) begin
                        if (rnd_q == 4'd15) begin
                            state_q        <= StIdle;
                            rnd_q          <= '0;
                            key_ready_q    <= 1'b1;
                            subkey_valid_q <= 1'b0;
                            last_q         <= 1'b0;
                        end else begin
                            c_q    <= adv_c;
                            d_q    <= adv_d;
                            rnd_q  <= rnd_q + 4'd1;
                            last_q <= (rnd_q == 4'd14);
                        end
                    end
                end
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey)
    );

    assign key_ready    = key_ready_q;
    assign subkey_valid = subkey_valid_q;
    assign round_idx    = rnd_q;
    assign last         = last_q;
    assign key_err      = key_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed self-checking bench for des_key_schedule using the classic 133457799BBCDFF1 key.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:64] key;
    logic        key_valid;
    logic        key_ready;
    logic        decrypt;
    logic [1:48] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        last;
    logic        key_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] GoodKey = 64'h133457799BBCDFF1;
    localparam logic [63:0] BadKey  = 64'h133457799BBCDFF0;

    // K1..K16 for GoodKey, worked out by hand from PC-1/PC-2 and the shift table.
    localparam logic [47:0] KsExp [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .decrypt      (decrypt),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .last         (last),
        .key_err      (key_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " key_ready"}, 64'(key_ready), 64'd1);
        check({tag, " subkey_valid"}, 64'(subkey_valid), 64'd0);
        check({tag, " last"}, 64'(last), 64'd0);
        check({tag, " round_idx"}, 64'(round_idx), 64'd0);
        check({tag, " subkey"}, 64'(subkey), 64'd0);
        check({tag, " key_err"}, 64'(key_err), 64'd0);
    endtask

    // Offer one key, then consume all 16 subkeys, checking each presented value
    // against the expected entry for the bench's own count of accepted subkeys.
    task automatic run_job(input string tag, input logic [63:0] k, input logic dec,
                           input bit backpressure, input bit poke_key);
        int  n = 0;
        int  cyc = 0;
        int  idx;
        bit  rdy;
        @(negedge clk);
        check({tag, " idle key_ready"}, 64'(key_ready), 64'd1);
        check({tag, " idle subkey_valid"}, 64'(subkey_valid), 64'd0);
        key          = k;
        decrypt      = dec;
        key_valid    = 1'b1;
        subkey_ready = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        key       = ~k;
        decrypt   = ~dec;
        check({tag, " run key_ready"}, 64'(key_ready), 64'd0);
        while (n < 16 && cyc < 400) begin
            idx = dec ? 15 - n : n;
            check($sformatf("%s valid %0d", tag, n), 64'(subkey_valid), 64'd1);
            check($sformatf("%s subkey %0d", tag, n), 64'(subkey), 64'(KsExp[idx[3:0]]));
            check($sformatf("%s round_idx %0d", tag, n), 64'(round_idx), 64'(n));
            check($sformatf("%s last %0d", tag, n), 64'(last), (n == 15) ? 64'd1 : 64'd0);
            check($sformatf("%s key_err %0d", tag, n), 64'(key_err), 64'd0);
            rdy          = backpressure ? ($urandom_range(0, 1) == 1) : 1'b1;
            subkey_ready = rdy;
            key_valid    = poke_key && (cyc % 3 == 0);
            @(negedge clk);
            if (rdy) n++;
            cyc++;
        end
        key_valid    = 1'b0;
        subkey_ready = 1'b0;
        if (n < 16) check({tag, " job timeout"}, 64'(n), 64'd16);
        check({tag, " done key_ready"}, 64'(key_ready), 64'd1);
        check({tag, " done subkey_valid"}, 64'(subkey_valid), 64'd0);
        check({tag, " done last"}, 64'(last), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst          = 1'b1;
        key          = '0;
        key_valid    = 1'b0;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_job("enc", GoodKey, 1'b0, 1'b0, 1'b0);
        run_job("dec", GoodKey, 1'b1, 1'b0, 1'b0);
        run_job("enc_bp", GoodKey, 1'b0, 1'b1, 1'b0);
        run_job("dec_bp", GoodKey, 1'b1, 1'b1, 1'b0);
        run_job("enc_poke", GoodKey, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a job, then a clean restart from K1.
        @(negedge clk);
        key          = GoodKey;
        decrypt      = 1'b0;
        key_valid    = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        cyc = 0;
        while (round_idx != 4'd7 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mid reach rnd7", 64'(round_idx), 64'd7);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid reset");
        @(negedge clk);
        rst          = 1'b0;
        subkey_ready = 1'b0;
        run_job("after_reset", GoodKey, 1'b0, 1'b0, 1'b0);

`ifdef DES_KS_PARITY_CHECK_EN
        @(negedge clk);
        key       = BadKey;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("parity key_err pulse", 64'(key_err), 64'd1);
        check("parity subkey_valid", 64'(subkey_valid), 64'd0);
        check("parity key_ready", 64'(key_ready), 64'd1);
        @(negedge clk);
        check("parity key_err clear", 64'(key_err), 64'd0);
        check("parity still idle", 64'(subkey_valid), 64'd0);
        run_job("after_parity", GoodKey, 1'b1, 1'b0, 1'b0);
`else
        // Parity bits are ignored, so the bad-parity key yields the same schedule.
        run_job("no_parity", BadKey, 1'b0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
